// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: stall/flush generation and trap/MRET drain-and-redirect FSM.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall/flush cycle counters.
module pipeline_ctrl #(
    parameter  int DRAIN_CYCLES = 2,
    localparam int CNT_W        = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       ex_write_rd_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [1:0] ex_result_src_i,
    input  logic       ex_bnj_taken_i,
    input  logic       ex_trap_i,
    input  logic       ex_trap_is_mret_i,
    input  logic       mem_busy_i,
    output logic       if_stall_o,
    output logic       ifid_flush_o,
    output logic       idex_stall_o,
    output logic       idex_flush_o,
    output logic       exmem_stall_o,
    output logic       exmem_flush_o,
    output logic       pc_redirect_o,
    output logic [1:0] pc_sel_o,
    output logic       trap_commit_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_CSR = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_MTVEC  = 2'b10;
    localparam logic [1:0] PC_MEPC   = 2'b11;

    typedef enum logic [1:0] {RUN, DRAIN, REDIRECT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             is_mret_q, is_mret_d;
    logic             use_hazard;

    // ALU producers are covered by forwarding; only MEM/CSR results arrive too late.
    assign use_hazard = id_valid_i && ex_write_rd_i && (ex_rd_addr_i != 5'd0)
                     && (ex_result_src_i == RESULT_MEM || ex_result_src_i == RESULT_CSR)
                     && (ex_rd_addr_i == id_rs1_addr_i || ex_rd_addr_i == id_rs2_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            is_mret_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            is_mret_q   <= is_mret_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        is_mret_d     = is_mret_q;
        if_stall_o    = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_stall_o = 1'b0;
        exmem_flush_o = 1'b0;
        pc_redirect_o = 1'b0;
        pc_sel_o      = PC_SEQ;
        trap_commit_o = 1'b0;
        if (rst_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_trap_i) begin
                        if_stall_o    = 1'b1;
                        ifid_flush_o  = 1'b1;
                        idex_flush_o  = 1'b1;
                        exmem_flush_o = 1'b1;
                        state_d       = DRAIN;
                        drain_cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                        is_mret_d     = ex_trap_is_mret_i;
                    end else if (mem_busy_i) begin
                        if_stall_o    = 1'b1;
                        idex_stall_o  = 1'b1;
                        exmem_stall_o = 1'b1;
                    end else if (ex_bnj_taken_i) begin
                        pc_redirect_o = 1'b1;
                        pc_sel_o      = PC_BRANCH;
                        ifid_flush_o  = 1'b1;
                        idex_flush_o  = 1'b1;
                    end else if (use_hazard) begin
                        if_stall_o    = 1'b1;
                        idex_flush_o  = 1'b1;
                    end
                end
                DRAIN: begin
                    // EX/MEM is left alone so the older memory op can retire.
                    if_stall_o   = 1'b1;
                    ifid_flush_o = 1'b1;
                    idex_flush_o = 1'b1;
                    if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - CNT_W'(1);
                    if (drain_cnt_q == '0 && !mem_busy_i) state_d = REDIRECT;
                end
                REDIRECT: begin
                    pc_redirect_o = 1'b1;
                    pc_sel_o      = is_mret_q ? PC_MEPC : PC_MTVEC;
                    trap_commit_o = 1'b1;
                    ifid_flush_o  = 1'b1;
                    idex_flush_o  = 1'b1;
                    state_d       = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (if_stall_o && perf_stall_cnt_o != 32'hFFFF_FFFF)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (idex_flush_o && perf_flush_cnt_o != 32'hFFFF_FFFF)
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl; outputs are packed into one vector and compared
// against hand-computed expectations each cycle.
module tb_pipeline_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       id_valid_i;
    logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
    logic       ex_write_rd_i;
    logic [1:0] ex_result_src_i;
    logic       ex_bnj_taken_i, ex_trap_i, ex_trap_is_mret_i, mem_busy_i;
    logic       if_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o;
    logic       exmem_stall_o, exmem_flush_o, pc_redirect_o, trap_commit_o;
    logic [1:0] pc_sel_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .ex_write_rd_i(ex_write_rd_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_result_src_i(ex_result_src_i),
        .ex_bnj_taken_i(ex_bnj_taken_i), .ex_trap_i(ex_trap_i), .ex_trap_is_mret_i(ex_trap_is_mret_i),
        .mem_busy_i(mem_busy_i),
        .if_stall_o(if_stall_o), .ifid_flush_o(ifid_flush_o), .idex_stall_o(idex_stall_o),
        .idex_flush_o(idex_flush_o), .exmem_stall_o(exmem_stall_o), .exmem_flush_o(exmem_flush_o),
        .pc_redirect_o(pc_redirect_o), .pc_sel_o(pc_sel_o), .trap_commit_o(trap_commit_o)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // {if_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, redirect, sel[1:0], commit}
    localparam logic [9:0] V_IDLE  = 10'b0_0_0_0_0_0_0_00_0;
    localparam logic [9:0] V_RST   = 10'b0_1_0_1_0_1_0_00_0;
    localparam logic [9:0] V_HAZ   = 10'b1_0_0_1_0_0_0_00_0;
    localparam logic [9:0] V_BR    = 10'b0_1_0_1_0_0_1_01_0;
    localparam logic [9:0] V_BUSY  = 10'b1_0_1_0_1_0_0_00_0;
    localparam logic [9:0] V_TRAP  = 10'b1_1_0_1_0_1_0_00_0;
    localparam logic [9:0] V_DRAIN = 10'b1_1_0_1_0_0_0_00_0;
    localparam logic [9:0] V_RDTV  = 10'b0_1_0_1_0_0_1_10_1;
    localparam logic [9:0] V_RDEP  = 10'b0_1_0_1_0_0_1_11_1;

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_CSR = 2'b10;

    function automatic logic [9:0] outs();
        return {if_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o, exmem_stall_o,
                exmem_flush_o, pc_redirect_o, pc_sel_o, trap_commit_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic wr, input logic [4:0] rd, input logic [1:0] src,
                       input logic bnj, input logic trap, input logic mret, input logic busy);
        id_valid_i = idv; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
        ex_write_rd_i = wr; ex_rd_addr_i = rd; ex_result_src_i = src;
        ex_bnj_taken_i = bnj; ex_trap_i = trap; ex_trap_is_mret_i = mret; mem_busy_i = busy;
    endtask

    task automatic idle();
        drv(0, 5'd0, 5'd0, 0, 5'd0, SRC_ALU, 0, 0, 0, 0);
    endtask

    // Inputs already applied: sample mid-cycle, then advance to just past the next edge.
    task automatic cyc(input string tag, input logic [9:0] exp);
        @(negedge clk_i);
        check(tag, 32'(outs()), 32'(exp));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        cyc("reset_outs", V_RST);
        cyc("reset_outs2", V_RST);
        rst_i = 1'b0;
        cyc("run_idle", V_IDLE);

        // Load-use on rs2: one bubble, then EX holds the bubble and it clears.
        drv(1, 5'd1, 5'd5, 1, 5'd5, SRC_MEM, 0, 0, 0, 0);
        cyc("load_use_rs2", V_HAZ);
        drv(1, 5'd1, 5'd5, 0, 5'd0, SRC_ALU, 0, 0, 0, 0);
        cyc("load_use_clear", V_IDLE);
        drv(1, 5'd0, 5'd0, 1, 5'd0, SRC_MEM, 0, 0, 0, 0);
        cyc("load_rd0", V_IDLE);
        drv(1, 5'd7, 5'd2, 1, 5'd7, SRC_CSR, 0, 0, 0, 0);
        cyc("csr_use_rs1", V_HAZ);
        drv(1, 5'd1, 5'd5, 1, 5'd5, SRC_ALU, 0, 0, 0, 0);
        cyc("alu_no_stall", V_IDLE);
        drv(0, 5'd1, 5'd5, 1, 5'd5, SRC_MEM, 0, 0, 0, 0);
        cyc("load_id_invalid", V_IDLE);

        // Taken branch: same-cycle redirect, then clean.
        drv(0, 5'd0, 5'd0, 0, 5'd0, SRC_ALU, 1, 0, 0, 0);
        cyc("branch", V_BR);
        idle();
        cyc("branch_after", V_IDLE);
        // Busy outranks branch and hazard.
        drv(1, 5'd5, 5'd0, 1, 5'd5, SRC_MEM, 1, 0, 0, 1);
        cyc("busy_prio", V_BUSY);
        drv(1, 5'd5, 5'd0, 1, 5'd5, SRC_MEM, 1, 0, 0, 0);
        cyc("busy_drop_branch", V_BR);

        // ECALL together with a taken branch: trap path wins; DRAIN ignores trap/branch.
        drv(0, 5'd0, 5'd0, 0, 5'd0, SRC_ALU, 1, 1, 0, 0);
        cyc("trap_entry", V_TRAP);
        drv(0, 5'd0, 5'd0, 0, 5'd0, SRC_ALU, 1, 1, 0, 0);
        cyc("drain1", V_DRAIN);
        idle();
        cyc("drain2", V_DRAIN);
        cyc("redirect_mtvec", V_RDTV);
        cyc("after_trap", V_IDLE);

        // MRET goes to mepc; busy on entry cycle is ignored.
        drv(0, 5'd0, 5'd0, 0, 5'd0, SRC_ALU, 0, 1, 1, 1);
        cyc("mret_entry", V_TRAP);
        idle();
        cyc("mret_drain1", V_DRAIN);
        cyc("mret_drain2", V_DRAIN);
        cyc("redirect_mepc", V_RDEP);
        cyc("after_mret", V_IDLE);

        // Busy for 3 cycles at drain end pushes redirect out by 3.
        drv(0, 5'd0, 5'd0, 0, 5'd0, SRC_ALU, 0, 1, 0, 0);
        cyc("tb_entry", V_TRAP);
        idle();
        cyc("tb_drain1", V_DRAIN);
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc("tb_drain_busy", V_DRAIN);
        mem_busy_i = 1'b0;
        cyc("tb_drain_last", V_DRAIN);
        cyc("tb_redirect", V_RDTV);
        cyc("tb_after", V_IDLE);

`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_nz", 32'(perf_stall_cnt_o != 0), 32'd1);
`endif

        // Reset mid-DRAIN: back to RUN with no commit pulse.
        drv(0, 5'd0, 5'd0, 0, 5'd0, SRC_ALU, 0, 1, 0, 0);
        cyc("rst_entry", V_TRAP);
        idle();
        cyc("rst_drain1", V_DRAIN);
        rst_i = 1'b1;
        cyc("rst_mid_drain", V_RST);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_rst", perf_stall_cnt_o, 32'd0);
        check("perf_flush_rst", perf_flush_cnt_o, 32'd0);
`endif
        rst_i = 1'b0;
        cyc("rst_after1", V_IDLE);
        cyc("rst_after2", V_IDLE);
        cyc("rst_after3", V_IDLE);
`ifdef PIPE_CTRL_PERF_EN
        drv(1, 5'd1, 5'd5, 1, 5'd5, SRC_MEM, 0, 0, 0, 0);
        cyc("perf_haz", V_HAZ);
        idle();
        check("perf_stall_one", perf_stall_cnt_o, 32'd1);
        check("perf_flush_one", perf_flush_cnt_o, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
